// File: rtl/issue_select.sv
// Issue select: picks up to N ready RS entries per cycle in rotating-priority order,
// honouring per-class unit availability, and latches them into the issue/execute register.
module issue_select #(
  parameter int N            = 2,
  parameter int RS_SZ        = 16,
  parameter int B_MASK_WIDTH = 4,
  parameter int PTR_BITS     = $clog2(RS_SZ),
  parameter int TAG_W        = 8,
  localparam int PKT_W       = TAG_W + 4 + B_MASK_WIDTH,
  localparam int CW          = $clog2(N) + 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [RS_SZ-1:0][PKT_W-1:0]   rs_data,
  input  logic [RS_SZ-1:0]              rs_valid,
  input  logic [3:0][CW-1:0]            fu_free,
  input  logic                          ex_ready,
  input  logic [B_MASK_WIDTH-1:0]       b_mm_resolve,
  input  logic                          b_mm_mispred,
  output logic [RS_SZ-1:0]              rs_data_issuing,
  output logic [N-1:0][PKT_W-1:0]       issue_packets,
  output logic [N-1:0]                  issue_valid,
  output logic [CW-1:0]                 issue_count
);

  // Packet layout: [1:0] fu_type, [B+1:2] b_mask, [B+2] Source1_ready, [B+3] Source2_ready, rest tag.
  localparam int MASK_LO = 2;
  localparam int MASK_HI = B_MASK_WIDTH + 1;
  localparam int S1_BIT  = B_MASK_WIDTH + 2;
  localparam int S2_BIT  = B_MASK_WIDTH + 3;

  function automatic logic [PKT_W-1:0] clr_mask(input logic [PKT_W-1:0] p,
                                                input logic [B_MASK_WIDTH-1:0] res);
    logic [PKT_W-1:0] q;
    q = p;
    q[MASK_HI:MASK_LO] = p[MASK_HI:MASK_LO] & ~res;
    return q;
  endfunction

  function automatic logic squashed(input logic [PKT_W-1:0] p,
                                    input logic [B_MASK_WIDTH-1:0] res,
                                    input logic mis);
    return mis && (|(p[MASK_HI:MASK_LO] & res));
  endfunction

  logic [N-1:0][PKT_W-1:0] r_pkts;
  logic [N-1:0]            r_valid;
  logic [PTR_BITS-1:0]     r_ptr;

  logic [RS_SZ-1:0]        w_cand;
  logic [RS_SZ-1:0]        w_sel_mask;
  logic [N-1:0][PKT_W-1:0] w_sel_pkts;
  logic [PTR_BITS-1:0]     w_last;
  logic [CW-1:0]           w_cnt;
  logic                    w_load;
  logic                    w_go;
  logic [PTR_BITS-1:0]     w_next_ptr;

  // Candidate qualification; no same-cycle wakeup bypass.
  always_comb begin
    w_cand = '0;
    for (int i = 0; i < RS_SZ; i++) begin
      w_cand[i] = rs_valid[i] && rs_data[i][S1_BIT] && rs_data[i][S2_BIT] &&
                  !squashed(rs_data[i], b_mm_resolve, b_mm_mispred);
    end
  end

  // Rotating scan from r_ptr; class-limited candidates are skipped, not blocking.
  always_comb begin
    int                  taken;
    int                  cls [4];
    logic [PTR_BITS-1:0] idx;
    logic [1:0]          fu;
    w_sel_mask = '0;
    w_sel_pkts = '0;
    w_last     = r_ptr;
    taken      = 0;
    cls        = '{default: 0};
    idx        = '0;
    fu         = 2'd0;
    for (int j = 0; j < RS_SZ; j++) begin
      idx = PTR_BITS'((int'(r_ptr) + j) % RS_SZ);
      fu  = rs_data[idx][1:0];
      if (w_cand[idx] && (taken < N) && (cls[fu] < int'(fu_free[fu]))) begin
        for (int k = 0; k < N; k++) begin
          if (k == taken) begin
            w_sel_pkts[k] = clr_mask(rs_data[idx], b_mm_resolve);
          end else begin
            w_sel_pkts[k] = w_sel_pkts[k];
          end
        end
        w_sel_mask[idx] = 1'b1;
        w_last          = idx;
        cls[fu]         = cls[fu] + 1;
        taken           = taken + 1;
      end else begin
        w_last = w_last;
      end
    end
    w_cnt = CW'(taken);
  end

  // Register accepts a new group when empty or when execute drains it.
  always_comb begin
    w_load          = !(|r_valid) || ex_ready;
    w_go            = w_load && !reset;
    rs_data_issuing = w_go ? w_sel_mask : '0;
    issue_count     = w_go ? w_cnt : '0;
    w_next_ptr      = PTR_BITS'((int'(w_last) + 1) % RS_SZ);
  end

  // Issue/execute register, pointer, and branch resolution on held packets.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pkts  <= '0;
      r_valid <= '0;
      r_ptr   <= '0;
    end else if (w_load) begin
      r_pkts <= w_sel_pkts;
      for (int k = 0; k < N; k++) begin
        r_valid[k] <= (k < int'(w_cnt));
      end
      if (w_cnt != '0) begin
        r_ptr <= w_next_ptr;
      end else begin
        r_ptr <= r_ptr;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        if (squashed(r_pkts[k], b_mm_resolve, b_mm_mispred)) begin
          r_valid[k] <= 1'b0;
        end else begin
          r_valid[k] <= r_valid[k];
        end
        r_pkts[k] <= clr_mask(r_pkts[k], b_mm_resolve);
      end
    end
  end

  assign issue_packets = r_pkts;
  assign issue_valid   = r_valid;

endmodule

// File: tb/tb_issue_select.sv
// Scoreboard bench for issue_select: stimulus pushes expectations, monitor pops and compares.
module tb_issue_select;

  logic                   clock = 1'b0;
  logic                   reset;
  logic [15:0][15:0]      rs_data;
  logic [15:0]            rs_valid;
  logic [3:0][1:0]        fu_free;
  logic                   ex_ready;
  logic [3:0]             b_mm_resolve;
  logic                   b_mm_mispred;
  logic [15:0]            rs_data_issuing;
  logic [1:0][15:0]       issue_packets;
  logic [1:0]             issue_valid;
  logic [1:0]             issue_count;

  int tests = 0;
  int fails = 0;

  typedef struct packed { logic [15:0] iss; logic [1:0] cnt; } comb_t;
  typedef struct packed {
    logic [1:0] vld; logic [7:0] t0; logic [3:0] m0; logic [7:0] t1; logic [3:0] m1; logic [3:0] ptr;
  } reg_t;

  comb_t q_comb[$];
  reg_t  q_reg[$];

  issue_select dut (
    .clock(clock), .reset(reset), .rs_data(rs_data), .rs_valid(rs_valid),
    .fu_free(fu_free), .ex_ready(ex_ready), .b_mm_resolve(b_mm_resolve),
    .b_mm_mispred(b_mm_mispred), .rs_data_issuing(rs_data_issuing),
    .issue_packets(issue_packets), .issue_valid(issue_valid), .issue_count(issue_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_rs();
    rs_data  = '0;
    rs_valid = '0;
  endtask

  // Packet = {tag(=index), s2, s1, b_mask, fu_type}
  task automatic ent(input int idx, input logic [1:0] fu, input logic [3:0] m,
                     input logic s1 = 1'b1, input logic s2 = 1'b1);
    logic [7:0] tag;
    tag           = 8'(idx);
    rs_data[idx]  = {tag, s2, s1, m, fu};
    rs_valid[idx] = 1'b1;
  endtask

  task automatic free(input logic [1:0] alu, input logic [1:0] mul,
                      input logic [1:0] mem, input logic [1:0] br);
    fu_free = {br, mem, mul, alu};
  endtask

  task automatic expect_step(input logic [15:0] iss, input logic [1:0] cnt, input logic [1:0] vld,
                             input logic [7:0] t0, input logic [3:0] m0,
                             input logic [7:0] t1, input logic [3:0] m1, input logic [3:0] ptr);
    q_comb.push_back('{iss: iss, cnt: cnt});
    q_reg.push_back('{vld: vld, t0: t0, m0: m0, t1: t1, m1: m1, ptr: ptr});
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #2;
    clear_rs();
  endtask

  // Combinational outputs checked mid-cycle.
  always @(negedge clock) begin
    comb_t c;
    if (q_comb.size() > 0) begin
      c = q_comb.pop_front();
      chk("rs_data_issuing", 32'(rs_data_issuing), 32'(c.iss));
      chk("issue_count", 32'(issue_count), 32'(c.cnt));
    end
  end

  // Register state checked just after the edge that captures it.
  always @(posedge clock) begin
    reg_t r;
    #1;
    if (q_reg.size() > 0 && q_comb.size() == 0) begin
      r = q_reg.pop_front();
      chk("issue_valid", 32'(issue_valid), 32'(r.vld));
      chk("ptr", 32'(dut.r_ptr), 32'(r.ptr));
      if (r.vld[0]) begin
        chk("slot0_tag", 32'(issue_packets[0][15:8]), 32'(r.t0));
        chk("slot0_mask", 32'(issue_packets[0][5:2]), 32'(r.m0));
      end
      if (r.vld[1]) begin
        chk("slot1_tag", 32'(issue_packets[1][15:8]), 32'(r.t1));
        chk("slot1_mask", 32'(issue_packets[1][5:2]), 32'(r.m1));
      end
    end
  end

  initial begin
    reset = 1'b1; ex_ready = 1'b1; b_mm_resolve = 4'd0; b_mm_mispred = 1'b0;
    clear_rs(); free(2'd2, 2'd0, 2'd0, 2'd0);

    // Reset held with ready entries: nothing issues
    next_cycle(); reset = 1'b1;
    for (int i = 0; i < 6; i++) ent(i, 2'd0, 4'd0);
    expect_step(16'h0000, 2'd0, 2'b00, 8'd0, 4'd0, 8'd0, 4'd0, 4'd0);

    next_cycle(); reset = 1'b0;
    for (int i = 0; i < 6; i++) ent(i, 2'd0, 4'd0);
    expect_step(16'h0003, 2'd2, 2'b11, 8'd0, 4'd0, 8'd1, 4'd0, 4'd2);

    // MULT class limit skips entry 4
    next_cycle(); free(2'd2, 2'd1, 2'd0, 2'd0);
    ent(3, 2'd1, 4'd0); ent(4, 2'd1, 4'd0); ent(5, 2'd0, 4'd0);
    expect_step(16'h0028, 2'd2, 2'b11, 8'd3, 4'd0, 8'd5, 4'd0, 4'd6);

    next_cycle(); ent(14, 2'd0, 4'd0);
    expect_step(16'h4000, 2'd1, 2'b01, 8'd14, 4'd0, 8'd0, 4'd0, 4'd15);

    // Wrap-around from ptr 15; entry 0 has Source2 not ready
    next_cycle(); ent(15, 2'd0, 4'd0); ent(1, 2'd0, 4'd0); ent(0, 2'd0, 4'd0, 1'b1, 1'b0);
    expect_step(16'h8002, 2'd2, 2'b11, 8'd15, 4'd0, 8'd1, 4'd0, 4'd2);

    // Stall
    next_cycle(); ex_ready = 1'b0; ent(7, 2'd0, 4'd0);
    expect_step(16'h0000, 2'd0, 2'b11, 8'd15, 4'd0, 8'd1, 4'd0, 4'd2);

    next_cycle(); ex_ready = 1'b1; ent(3, 2'd0, 4'd0); ent(4, 2'd0, 4'b0100);
    expect_step(16'h0018, 2'd2, 2'b11, 8'd3, 4'd0, 8'd4, 4'b0100, 4'd5);

    // Mispredict squashes held slot1
    next_cycle(); ex_ready = 1'b0; b_mm_resolve = 4'b0100; b_mm_mispred = 1'b1;
    ent(2, 2'd0, 4'b0100);
    expect_step(16'h0000, 2'd0, 2'b01, 8'd3, 4'd0, 8'd0, 4'd0, 4'd5);

    // Mispredict-dependent entry never selected even when loading
    next_cycle(); ex_ready = 1'b1; ent(2, 2'd0, 4'b0100);
    expect_step(16'h0000, 2'd0, 2'b00, 8'd0, 4'd0, 8'd0, 4'd0, 4'd5);

    next_cycle(); b_mm_resolve = 4'd0; b_mm_mispred = 1'b0;
    ent(5, 2'd0, 4'd0); ent(6, 2'd0, 4'b0100);
    expect_step(16'h0060, 2'd2, 2'b11, 8'd5, 4'd0, 8'd6, 4'b0100, 4'd7);

    // Correct prediction: held mask cleared while stalled
    next_cycle(); ex_ready = 1'b0; b_mm_resolve = 4'b0100; ent(2, 2'd0, 4'b0100);
    expect_step(16'h0000, 2'd0, 2'b11, 8'd5, 4'd0, 8'd6, 4'd0, 4'd7);

    // Entry 2 issues with resolved bit cleared
    next_cycle(); ex_ready = 1'b1; ent(2, 2'd0, 4'b0100);
    expect_step(16'h0004, 2'd1, 2'b01, 8'd2, 4'd0, 8'd0, 4'd0, 4'd3);

    next_cycle(); b_mm_resolve = 4'd0; free(2'd2, 2'd0, 2'd1, 2'd1);
    ent(3, 2'd3, 4'd0); ent(4, 2'd2, 4'd0); ent(5, 2'd2, 4'd0); ent(6, 2'd0, 4'd0);
    expect_step(16'h0018, 2'd2, 2'b11, 8'd3, 4'd0, 8'd4, 4'd0, 4'd5);

    // No ALU units free: nothing issues, register drains
    next_cycle(); free(2'd0, 2'd2, 2'd0, 2'd0); ent(5, 2'd0, 4'd0); ent(6, 2'd0, 4'd0);
    expect_step(16'h0000, 2'd0, 2'b00, 8'd0, 4'd0, 8'd0, 4'd0, 4'd5);

    next_cycle(); free(2'd2, 2'd0, 2'd1, 2'd0);
    ent(5, 2'd2, 4'd0); ent(6, 2'd2, 4'd0); ent(7, 2'd0, 4'd0);
    expect_step(16'h00A0, 2'd2, 2'b11, 8'd5, 4'd0, 8'd7, 4'd0, 4'd8);

    next_cycle(); ent(9, 2'd0, 4'd0);
    expect_step(16'h0200, 2'd1, 2'b01, 8'd9, 4'd0, 8'd0, 4'd0, 4'd10);

    // Reset while register valid
    next_cycle(); reset = 1'b1; ent(1, 2'd0, 4'd0); ent(9, 2'd0, 4'd0);
    expect_step(16'h0000, 2'd0, 2'b00, 8'd0, 4'd0, 8'd0, 4'd0, 4'd0);

    next_cycle(); reset = 1'b0; ent(1, 2'd0, 4'd0); ent(9, 2'd0, 4'd0);
    expect_step(16'h0202, 2'd2, 2'b11, 8'd1, 4'd0, 8'd9, 4'd0, 4'd10);

    next_cycle();
    for (int i = 0; i < 10 && (q_comb.size() > 0 || q_reg.size() > 0); i++) @(posedge clock);
    #3;
    tests++;
    if (q_comb.size() > 0 || q_reg.size() > 0) begin
      fails++;
      $display("FAIL drain actual=%0d/%0d pending required=0", q_comb.size(), q_reg.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/issue_select.md
Name: issue_select

Overview:
- Issue stage directly downstream of the reservation station (RS).
- Each cycle it scans the RS contents and picks up to N ready entries, subject to per-class functional-unit availability.
- It returns a one-hot-per-entry issue vector (rs_data_issuing) to the RS and latches the chosen packets into an issue/execute pipeline register.
- A rotating priority pointer provides fairness. Latched packets are squashed or have their branch masks cleared on branch resolution.

Parameters:
- N, 2, superscalar width (issue slots).
- RS_SZ, 16, RS entries.
- B_MASK_WIDTH, 4, branch-mask width.
- PTR_BITS, $clog2(RS_SZ), priority pointer width.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- rs_data  in  RS_PACKET x RS_SZ  full RS contents. Uses Source1_ready, Source2_ready, b_mask and fu_type (2b: 0 ALU, 1 MULT, 2 MEM, 3 BR).
- rs_valid  in  RS_SZ  valid bit per RS entry.
- fu_free  in  4 x ($clog2(N)+1)  free unit count per fu_type this cycle.
- ex_ready  in  1  execute stage accepts the issue register contents this cycle.
- b_mm_resolve  in  B_MASK_WIDTH  one-hot branch being resolved (0 = none).
- b_mm_mispred  in  1  the resolving branch mispredicted.
- rs_data_issuing  out  RS_SZ  entries issued this cycle (combinational). The RS frees them next edge.
- issue_packets  out  RS_PACKET x N  issue/execute register contents.
- issue_valid  out  N  valid per issue slot.
- issue_count  out  $clog2(N)+1  popcount of rs_data_issuing.

Behaviour:
- Reset clears issue_valid, issue_packets and the pointer (ptr=0). While reset is asserted, rs_data_issuing is forced to 0.
- Candidate rule: rs_valid[i] && Source1_ready && Source2_ready && !(b_mm_mispred && (b_mask & b_mm_resolve)).
  - There is no same-cycle CDB bypass. Wakeup becomes visible only through RS readiness on the following cycle.
- Selection order: scan indices ptr, ptr+1, ..., ptr+RS_SZ-1, modulo RS_SZ (wrap-around).
  - Take a candidate only while fewer than N have been taken and the per-class taken count is below fu_free[fu_type].
  - Candidates that fail the class check are skipped; the scan continues.
  - Slot k holds the k-th taken entry in scan order. Slots are filled contiguously from slot 0.
- Handshake / stall: load is asserted when !(|issue_valid) || ex_ready.
  - If load is low, rs_data_issuing = 0 and the register holds.
  - If load is high, the register captures the selected packets, with issue_valid[k] = (k < issue_count).
- Pointer update: when load && issue_count>0, ptr <= (index of last taken entry + 1) mod RS_SZ. Otherwise ptr holds.
- Branch resolve on register contents, applied every cycle, whether stalled or not:
  - If b_mm_mispred and (b_mask & b_mm_resolve) != 0, issue_valid[k] <= 0.
  - Otherwise b_mask <= b_mask & ~b_mm_resolve.
- Branch resolve on newly captured packets: the b_mm_resolve bit is also cleared before latching.
  - Mispredicted-dependent entries are never selected.
- Latency: RS entry ready at cycle t → issue_valid at t+1 (one register stage).
- Invariants:
  - issue_count <= N.
  - rs_data_issuing ⊆ rs_valid.
  - Per class, taken count <= fu_free.
  - No entry is issued twice, since the RS clears it at the same edge.

Test Plan:
- Reset, then RS entries 0–5 valid and ready, all ALU, fu_free ALU=2, ex_ready=1 → rs_data_issuing=0x0003, issue_count=2. Next cycle: issue_valid=2'b11, slots hold entries 0 and 1, ptr=2.
- Entries 3 and 4 MULT, entry 5 ALU, ptr=3, fu_free MULT=1, ALU=2 → issues entries 3 and 5 (mask 0x0028). Entry 4 is skipped.
- ptr=15, entries 15 and 1 ready → rs_data_issuing=0x8002, slot0=entry 15, slot1=entry 1, ptr=2 (wrap-around).
- Register full with ex_ready=0 while entry 7 is ready → rs_data_issuing=0, register unchanged, ptr unchanged.
- Mispredict: register slot1 holds b_mask=4'b0100; b_mm_resolve=4'b0100, b_mm_mispred=1. RS entry 2 is ready with a matching mask.
  - Required: issue_valid[1]=0 next cycle, entry 2 not issued.
  - With b_mm_mispred=0 instead: slot1 keeps valid, b_mask becomes 4'b0000, and entry 2 issues with b_mask cleared.
- Assert reset while the register is valid → next cycle issue_valid=0, ptr=0, rs_data_issuing=0 during reset.
